// File: rtl/bus_protocol_arbiter.sv
// Round-robin arbiter and dValid/dAck bus master for NREQ requesters.
// Define BUS_ARB_RETRY_EN to keep the round-robin pointer on a timed-out requester.
module bus_protocol_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MIN_VALID = 2,
    parameter int MAX_VALID = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    done,
    output logic [NREQ-1:0]    err,
    output logic               early_ack,
    output logic               busy,
    output logic               dValid,
    output logic [DW-1:0]      data,
    input  logic               dAck
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [2:0] MINV = 3'(MIN_VALID);
    localparam logic [2:0] MAXV = 3'(MAX_VALID);
    localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

    typedef enum logic {
        IDLE,
        VALID
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   id_q, id_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [DW-1:0]   data_q, data_d;
    logic            dvalid_q, dvalid_d;
    logic            busy_q, busy_d;
    logic            early_q, early_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] err_q, err_d;

    logic            found;
    logic [IW-1:0]   win;
    logic [IW-1:0]   cand;
    logic [IW-1:0]   id_nxt;
    logic [2:0]      cnt_inc;

    // Scan from ptr upward, wrapping; first requester found wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(ptr_q) + i) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign id_nxt  = (id_q == LAST) ? '0 : id_q + 1'b1;
    assign cnt_inc = (cnt_q >= MAXV) ? MAXV : cnt_q + 3'd1;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        dvalid_d = dvalid_q;
        early_d  = 1'b0;
        done_d   = '0;
        err_d    = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    id_d     = win;
                    data_d   = req_data[int'(win)*DW +: DW];
                    dvalid_d = 1'b1;
                    cnt_d    = 3'd1;
                    state_d  = VALID;
                end
            end
            VALID: begin
                if (dAck && cnt_q >= MINV) begin
                    dvalid_d     = 1'b0;
                    done_d[id_q] = 1'b1;
                    ptr_d        = id_nxt;
                    cnt_d        = '0;
                    state_d      = IDLE;
                end else if (dAck) begin
                    early_d = 1'b1;
                    cnt_d   = cnt_inc;
                end else if (cnt_q >= MAXV) begin
                    dvalid_d    = 1'b0;
                    err_d[id_q] = 1'b1;
`ifdef BUS_ARB_RETRY_EN
                    ptr_d       = id_q;
`else
                    ptr_d       = id_nxt;
`endif
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == VALID);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            id_q     <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            dvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            early_q  <= 1'b0;
            done_q   <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            dvalid_q <= dvalid_d;
            busy_q   <= busy_d;
            early_q  <= early_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign dValid    = dvalid_q;
    assign data      = data_q;
    assign busy      = busy_q;
    assign early_ack = early_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bus_protocol_arbiter.sv
// Transaction-level bench for bus_protocol_arbiter: each transfer's winner,
// dValid length and pulses are predicted from the bus rules and checked per cycle.
module tb_bus_protocol_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int MINV = 2;
    localparam int MAXV = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    done;
    logic [NREQ-1:0]    err;
    logic               early_ack;
    logic               busy;
    logic               dValid;
    logic [DW-1:0]      data;
    logic               dAck;

    bus_protocol_arbiter #(
        .NREQ(NREQ), .DW(DW), .MIN_VALID(MINV), .MAX_VALID(MAXV)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .done(done), .err(err), .early_ack(early_ack), .busy(busy),
        .dValid(dValid), .data(data), .dAck(dAck)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;
    int mptr   = 0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] pl [NREQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        req = '0;
        repeat (n) begin
            @(posedge clk); #1;
            chk("idle_valid", 32'(dValid), 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_data", 32'(data), 32'(last_data));
            chk("idle_done", 32'(done), 0);
            chk("idle_err", 32'(err), 0);
            chk("idle_early", 32'(early_ack), 0);
            dAck = 1'($urandom_range(0, 1));
        end
    endtask

    // Entered in an IDLE cycle at posedge+1; leaves in the following IDLE cycle.
    task automatic do_xfer(input logic [3:0] mask, input logic [7:0] ap,
                           input bit chg, input bit drop, input bit fix_a5);
        int w, len;
        bit acked;
        logic [7:0] pd;
        logic [3:0] onehot;
        w = -1;
        for (int i = 0; i < NREQ; i++)
            if (w < 0 && mask[(mptr + i) % NREQ]) w = (mptr + i) % NREQ;
        for (int i = 0; i < NREQ; i++) pl[i] = 8'($urandom);
        if (fix_a5) pl[0] = 8'hA5;
        req_data = {pl[3], pl[2], pl[1], pl[0]};
        pd = pl[w];
        onehot = 4'(1 << w);
        len = MAXV;
        acked = 0;
        for (int c = MINV; c <= MAXV; c++)
            if (!acked && ap[c]) begin
                len = c;
                acked = 1;
            end
        req = mask;
        @(posedge clk); #1;
        chk("grant_valid", 32'(dValid), 1);
        chk("grant_busy", 32'(busy), 1);
        chk("grant_data", 32'(data), 32'(pd));
        chk("grant_done", 32'(done), 0);
        chk("grant_err", 32'(err), 0);
        chk("grant_early", 32'(early_ack), 0);
        for (int c = 1; c <= len; c++) begin
            dAck = ap[c];
            if (chg) req_data = $urandom;
            if (drop) req = '0;
            @(posedge clk); #1;
            chk("xfer_valid", 32'(dValid), 32'(c < len));
            chk("xfer_busy", 32'(busy), 32'(c < len));
            chk("xfer_data", 32'(data), 32'(pd));
            chk("xfer_done", 32'(done), (c == len && acked) ? 32'(onehot) : 0);
            chk("xfer_err", 32'(err), (c == len && !acked) ? 32'(onehot) : 0);
            chk("xfer_early", 32'(early_ack), 32'(ap[c] && c < MINV));
        end
`ifdef BUS_ARB_RETRY_EN
        mptr = acked ? (w + 1) % NREQ : w;
`else
        mptr = (w + 1) % NREQ;
`endif
        last_data = pd;
        dAck = 1'($urandom_range(0, 1));
    endtask

    initial begin
        reset = 1'b1;
        req = '0;
        req_data = '0;
        dAck = 1'b0;
        #2;
        chk("rst_valid", 32'(dValid), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_early", 32'(early_ack), 0);
        #20 reset = 1'b0;
        @(posedge clk); #1;

        // Round robin: all requesting, acked on cnt=3 -> order 0,1,2,3,0
        for (int t = 0; t < 5; t++) do_xfer(4'b1111, 8'b0000_1000, 0, 0, 0);
        idle(2);
        // Single transfer acked on the second high cycle
        do_xfer(4'b0001, 8'b0000_0100, 0, 0, 1);
        idle(1);
        // Early ack on cnt=1, real ack on cnt=3
        do_xfer(4'b0010, 8'b0000_1010, 0, 0, 0);
        // Timeout then re-arbitration between 0 and 1
        do_xfer(4'b0011, 8'b0000_0000, 0, 0, 0);
        do_xfer(4'b0011, 8'b0000_0100, 0, 0, 0);
        // Data stability with payload churn and dropped req
        do_xfer(4'b1000, 8'b0001_0000, 1, 1, 0);

        // Reset mid-transfer on cnt=2, with ptr moved away from 0
        do_xfer(4'b0001, 8'b0000_0100, 0, 0, 0);
        req = 4'b0001;
        @(posedge clk); #1;
        chk("pre_rst_valid", 32'(dValid), 1);
        dAck = 1'b0;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(dValid), 0);
        chk("mid_rst_data", 32'(data), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        req = '0;
        @(posedge clk); #1;
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_err", 32'(err), 0);
        #3 reset = 1'b0;
        mptr = 0;
        last_data = 8'h00;
        idle(1);
        do_xfer(4'b0101, 8'b0000_0100, 0, 0, 0);
        do_xfer(4'b0100, 8'b0000_1000, 0, 0, 0);

        for (int t = 0; t < 80; t++) begin
            logic [3:0] m;
            logic [7:0] a;
            m = 4'($urandom_range(1, 15));
            a = 8'($urandom);
            if ($urandom_range(0, 3) == 0) a = a & 8'b0000_0011;
            do_xfer(m, a, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 0);
            if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
